// File: rtl/barrel_shift_pkg.sv
// Shared mode encodings, stage control payload and bit-reverse helper for the
// pipelined barrel shifter.
package barrel_shift_pkg;

    localparam int MAX_W = 256;

    typedef enum logic [2:0] {
        MODE_SLL = 3'b000,
        MODE_SRL = 3'b001,
        MODE_SRA = 3'b010,
        MODE_ROL = 3'b011,
        MODE_ROR = 3'b100
    } mode_e;

    // Data and shamt widths depend on the instance, so they travel beside this record.
    typedef struct packed {
        logic [2:0] mode;
        logic       rev;
        logic       ovf;
    } stage_ctrl_t;

    localparam int CTRL_W = $bits(stage_ctrl_t);

    function automatic logic [MAX_W-1:0] bit_reverse(input logic [MAX_W-1:0] x);
        logic [MAX_W-1:0] r;
        for (int i = 0; i < MAX_W; i++) begin
            r[i] = x[MAX_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/barrel_shift_stage.sv
// One mux level (fixed distance 2^K) with its valid/ready slice, or a plain
// combinational bypass when REG=0. Overflow tracking under BARREL_SHIFT_OVF_EN.
module barrel_shift_stage
    import barrel_shift_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4,
    parameter int K       = 0,
    parameter bit REG     = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [CTRL_W-1:0]  in_ctrl,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SHAMT_W-1:0] out_shamt,
    output logic [CTRL_W-1:0]  out_ctrl
);

    localparam int DIST = 1 << K;

    stage_ctrl_t      ctrl_in;
    stage_ctrl_t      ctrl_next;
    logic [WIDTH-1:0] shifted;
    logic             ovf_level;

    assign ctrl_in = in_ctrl;

    // Left ops arrive bit-reversed, so SLL/ROL are executed as SRL/ROR here.
    always_comb begin
        shifted   = in_data;
        ovf_level = 1'b0;
        if (in_shamt[K]) begin
            case (ctrl_in.mode)
                MODE_SLL, MODE_SRL: shifted = in_data >> DIST;
                MODE_SRA:           shifted = $signed(in_data) >>> DIST;
                MODE_ROL, MODE_ROR: shifted = (in_data >> DIST) | (in_data << (WIDTH - DIST));
                default:            shifted = in_data;
            endcase
`ifdef BARREL_SHIFT_OVF_EN
            if (ctrl_in.mode == MODE_SLL) begin
                for (int i = 0; i < DIST; i++) begin
                    if (in_data[i] != in_data[DIST]) begin
                        ovf_level = 1'b1;
                    end
                end
            end
`endif
        end
    end

    always_comb begin
        ctrl_next     = ctrl_in;
        ctrl_next.ovf = ctrl_in.ovf | ovf_level;
    end

    if (REG) begin : g_reg
        logic               valid_q;
        logic [WIDTH-1:0]   data_q;
        logic [SHAMT_W-1:0] shamt_q;
        logic [CTRL_W-1:0]  ctrl_q;

        assign in_ready = ~valid_q | out_ready;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                shamt_q <= '0;
                ctrl_q  <= '0;
            end else begin
                if (in_ready) begin
                    valid_q <= in_valid;
                end
                if (in_valid && in_ready) begin
                    data_q  <= shifted;
                    shamt_q <= in_shamt;
                    ctrl_q  <= ctrl_next;
                end
            end
        end

        assign out_valid = valid_q;
        assign out_data  = data_q;
        assign out_shamt = shamt_q;
        assign out_ctrl  = ctrl_q;
    end else begin : g_bypass
        logic unused_clk;
        assign unused_clk = clk_i ^ rst_i;
        assign in_ready   = out_ready;
        assign out_valid  = in_valid;
        assign out_data   = shifted;
        assign out_shamt  = in_shamt;
        assign out_ctrl   = ctrl_next;
    end

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined multi-mode barrel shifter with valid/ready streaming on both sides.
// Define BARREL_SHIFT_OVF_EN to add the out_ovf_o signed-overflow flag for SLL.
module barrel_shift_pipe
    import barrel_shift_pkg::*;
#(
    parameter int   WIDTH   = 16,
    parameter int   PIPE    = 1,
    localparam int  SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WIDTH-1:0]   in_data_i,
    input  logic [SHAMT_W-1:0] in_shamt_i,
    input  logic [2:0]         in_mode_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [WIDTH-1:0]   out_data_o
`ifdef BARREL_SHIFT_OVF_EN
    ,
    output logic               out_ovf_o
`endif
);

    localparam int LAST = SHAMT_W - 1;

    if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0 || WIDTH >= MAX_W) begin : g_bad_width
        $error("barrel_shift_pipe: WIDTH must be a power of two, at least 4 and below %0d", MAX_W);
    end
    if (PIPE != 0 && PIPE != 1) begin : g_bad_pipe
        $error("barrel_shift_pipe: PIPE must be 0 or 1");
    end

    logic             rev_in;
    logic [MAX_W-1:0] rev_in_full;
    logic [MAX_W-1:0] rev_out_full;
    logic [WIDTH-1:0] stage0_data;
    stage_ctrl_t      stage0_ctrl;

    // Left operations are reversed on entry and undone on exit.
    assign rev_in      = (in_mode_i == MODE_SLL) || (in_mode_i == MODE_ROL);
    assign rev_in_full = bit_reverse(MAX_W'(in_data_i));
    assign stage0_data = rev_in ? rev_in_full[MAX_W-1 -: WIDTH] : in_data_i;

    always_comb begin
        stage0_ctrl      = '0;
        stage0_ctrl.mode = in_mode_i;
        stage0_ctrl.rev  = rev_in;
    end

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_lvl
        logic               src_valid;
        logic [WIDTH-1:0]   src_data;
        logic [SHAMT_W-1:0] src_shamt;
        stage_ctrl_t        src_ctrl;
        logic               acc_ready;
        logic               dn_ready;
        logic               valid;
        logic [WIDTH-1:0]   data;
        logic [SHAMT_W-1:0] shamt;
        stage_ctrl_t        ctrl;

        if (k == 0) begin : g_src
            assign src_valid = in_valid_i;
            assign src_data  = stage0_data;
            assign src_shamt = in_shamt_i;
            assign src_ctrl  = stage0_ctrl;
        end else begin : g_src
            assign src_valid = g_lvl[k-1].valid;
            assign src_data  = g_lvl[k-1].data;
            assign src_shamt = g_lvl[k-1].shamt;
            assign src_ctrl  = g_lvl[k-1].ctrl;
        end

        if (k == LAST) begin : g_dn
            assign dn_ready = out_ready_i;
        end else begin : g_dn
            assign dn_ready = g_lvl[k+1].acc_ready;
        end

        barrel_shift_stage #(
            .WIDTH   (WIDTH),
            .SHAMT_W (SHAMT_W),
            .K       (k),
            .REG     (PIPE == 1 || k == LAST)
        ) u_stage (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .in_valid  (src_valid),
            .in_ready  (acc_ready),
            .in_data   (src_data),
            .in_shamt  (src_shamt),
            .in_ctrl   (src_ctrl),
            .out_valid (valid),
            .out_ready (dn_ready),
            .out_data  (data),
            .out_shamt (shamt),
            .out_ctrl  (ctrl)
        );
    end

    assign in_ready_o   = g_lvl[0].acc_ready;
    assign out_valid_o  = g_lvl[LAST].valid;
    assign rev_out_full = bit_reverse(MAX_W'(g_lvl[LAST].data));
    assign out_data_o   = g_lvl[LAST].ctrl.rev ? rev_out_full[MAX_W-1 -: WIDTH] : g_lvl[LAST].data;

`ifdef BARREL_SHIFT_OVF_EN
    assign out_ovf_o = g_lvl[LAST].ctrl.ovf;
`endif

    logic unused_bits;
    assign unused_bits = ^{rev_in_full[MAX_W-WIDTH-1:0], rev_out_full[MAX_W-WIDTH-1:0],
                           g_lvl[LAST].shamt, g_lvl[LAST].ctrl.mode, g_lvl[LAST].ctrl.ovf};

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Self-checking bench for barrel_shift_pipe (WIDTH=16, PIPE=1): directed vector
// table, backpressure and mid-stream reset sequences, and a randomized scoreboard run.
module tb_barrel_shift_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0;
    logic [3:0]  in_shamt = 4'h0;
    logic [2:0]  in_mode = 3'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
`ifdef BARREL_SHIFT_OVF_EN
    logic        out_ovf;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int out_seen = 0;

    logic [16:0] exp_q[$];
    int          acc_q[$];
    bit          accepted;
    bit          consumed;
    logic [15:0] cons_data;
    logic        cons_ovf;
    int          cons_lat;
    logic        s_valid;
    logic        s_oready;
    logic        s_in_ready;
    logic [15:0] s_data;

    typedef struct {
        logic [2:0]  mode;
        logic [15:0] data;
        logic [3:0]  shamt;
        logic [15:0] exp;
        logic        exp_ovf;
        string       name;
    } vec_t;

    vec_t vecs[12];

    barrel_shift_pipe #(
        .WIDTH (16),
        .PIPE  (1)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_shamt_i  (in_shamt),
        .in_mode_i   (in_mode),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data)
`ifdef BARREL_SHIFT_OVF_EN
        ,
        .out_ovf_o   (out_ovf)
`endif
    );

    always #5 clk = ~clk;

    // Reference: the shift rules stated directly as arithmetic on the whole word.
    function automatic logic [16:0] model(input logic [2:0] mode, input logic [15:0] d, input logic [3:0] s);
        logic [31:0] dd;
        logic [15:0] r;
        logic        ovf;
        int          n;
        int          top;
        dd  = {d, d};
        r   = d;
        ovf = 1'b0;
        n   = int'(s);
        case (mode)
            3'd0: begin
                r   = d << n;
                top = int'(d) >> (15 - n);
                ovf = !(top == 0 || top == ((1 << (n + 1)) - 1));
            end
            3'd1: r = d >> n;
            3'd2: r = (d >> n) | (d[15] ? ~(16'hFFFF >> n) : 16'h0);
            3'd3: begin dd = dd << n; r = dd[31:16]; end
            3'd4: begin dd = dd >> n; r = dd[15:0]; end
            default: r = d;
        endcase
        return {ovf, r};
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic note_timeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got timeout, expected a response (cycle %0d)", name, cyc);
    endtask

    task automatic apply_stimulus(input logic v, input logic [15:0] d, input logic [3:0] s,
                                  input logic [2:0] m, input logic ordy);
        in_valid  = v;
        in_data   = d;
        in_shamt  = s;
        in_mode   = m;
        out_ready = ordy;
    endtask

    // One clock: observe settled outputs on the falling edge, update the scoreboard.
    task automatic cycle();
        logic [16:0] e;
        @(negedge clk);
        accepted   = 1'b0;
        consumed   = 1'b0;
        s_valid    = out_valid;
        s_oready   = out_ready;
        s_in_ready = in_ready;
        s_data     = out_data;
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                consumed  = 1'b1;
                out_seen++;
                cons_data = out_data;
`ifdef BARREL_SHIFT_OVF_EN
                cons_ovf  = out_ovf;
`endif
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_result: got 0x%0h, expected no result (cycle %0d)", out_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    cons_lat = cyc - acc_q.pop_front();
                    check_output("sb_data", 32'(out_data), 32'(e[15:0]));
`ifdef BARREL_SHIFT_OVF_EN
                    check_output("sb_ovf", 32'(out_ovf), 32'(e[16]));
`endif
                end
            end
            if (in_valid && in_ready) begin
                accepted = 1'b1;
                exp_q.push_back(model(in_mode, in_data, in_shamt));
                acc_q.push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_reset(input string name);
        @(negedge clk);
        check_output({name, "_out_valid"}, 32'(out_valid), 32'h0);
        check_output({name, "_out_data"}, 32'(out_data), 32'h0);
        check_output({name, "_in_ready"}, 32'(in_ready), 32'h1);
`ifdef BARREL_SHIFT_OVF_EN
        check_output({name, "_out_ovf"}, 32'(out_ovf), 32'h0);
`endif
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        bit          got;
        bit          low_seen;
        bit          prev_stall;
        logic [15:0] prev_data;
        logic [15:0] cur_d;
        logic [3:0]  cur_s;
        logic [2:0]  cur_m;
        int          sent;
        int          base;
        int          gaps;
        int          n_acc;

        vecs[0]  = '{3'b000, 16'h0001, 4'd15, 16'h8000, 1'b1, "sll_0001_15"};
        vecs[1]  = '{3'b000, 16'h00FF, 4'd4,  16'h0FF0, 1'b0, "sll_00ff_4"};
        vecs[2]  = '{3'b010, 16'h8000, 4'd3,  16'hF000, 1'b0, "sra_8000_3"};
        vecs[3]  = '{3'b001, 16'h8000, 4'd3,  16'h1000, 1'b0, "srl_8000_3"};
        vecs[4]  = '{3'b010, 16'h7FF0, 4'd4,  16'h07FF, 1'b0, "sra_7ff0_4"};
        vecs[5]  = '{3'b011, 16'h8001, 4'd1,  16'h0003, 1'b0, "rol_8001_1"};
        vecs[6]  = '{3'b100, 16'h8001, 4'd1,  16'hC000, 1'b0, "ror_8001_1"};
        vecs[7]  = '{3'b100, 16'h1234, 4'd0,  16'h1234, 1'b0, "ror_1234_0"};
        vecs[8]  = '{3'b110, 16'hBEEF, 4'd7,  16'hBEEF, 1'b0, "pass_beef_7"};
        vecs[9]  = '{3'b000, 16'h4000, 4'd1,  16'h8000, 1'b1, "sll_4000_1"};
        vecs[10] = '{3'b000, 16'h0003, 4'd2,  16'h000C, 1'b0, "sll_0003_2"};
        vecs[11] = '{3'b010, 16'h8000, 4'd4,  16'hF800, 1'b0, "sra_8000_4"};
        cons_ovf = 1'b0;

        apply_stimulus(1'b0, 16'h0, 4'h0, 3'h0, 1'b0);
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        check_reset("reset");

        foreach (vecs[i]) begin
            apply_stimulus(1'b1, vecs[i].data, vecs[i].shamt, vecs[i].mode, 1'b1);
            got = 1'b0;
            for (int w = 0; w < 10; w++) begin
                cycle();
                if (accepted) begin got = 1'b1; break; end
            end
            apply_stimulus(1'b0, 16'h0, 4'h0, 3'h0, 1'b1);
            if (!got) begin
                note_timeout({vecs[i].name, "_accept"});
            end else begin
                got = 1'b0;
                for (int w = 0; w < 12; w++) begin
                    cycle();
                    if (consumed) begin got = 1'b1; break; end
                end
                if (!got) begin
                    note_timeout({vecs[i].name, "_result"});
                end else begin
                    check_output({vecs[i].name, "_data"}, 32'(cons_data), 32'(vecs[i].exp));
                    check_output({vecs[i].name, "_latency"}, 32'(cons_lat), 32'd4);
`ifdef BARREL_SHIFT_OVF_EN
                    check_output({vecs[i].name, "_ovf"}, 32'(cons_ovf), 32'(vecs[i].exp_ovf));
`endif
                end
            end
        end

        // Ten back-to-back beats with the consumer stalled for cycles 6..12.
        sent = 0; base = out_seen; gaps = 0; low_seen = 1'b0; prev_stall = 1'b0; prev_data = 16'h0;
        cur_d = 16'($urandom); cur_s = 4'($urandom_range(0, 15)); cur_m = 3'($urandom_range(0, 7));
        for (int c = 0; c < 60 && (out_seen - base) < 10; c++) begin
            apply_stimulus(sent < 10, (sent < 10) ? cur_d : 16'h0, cur_s, cur_m, !(c >= 6 && c <= 12));
            cycle();
            if (accepted) begin
                sent++;
                cur_d = 16'($urandom); cur_s = 4'($urandom_range(0, 15)); cur_m = 3'($urandom_range(0, 7));
            end
            if (s_valid && !s_oready) begin
                if (prev_stall) check_output("stall_hold", 32'(s_data), 32'(prev_data));
                prev_stall = 1'b1;
                prev_data  = s_data;
            end else begin
                prev_stall = 1'b0;
            end
            if (!s_in_ready && !low_seen) begin
                low_seen = 1'b1;
                check_output("held_beats", 32'(exp_q.size()), 32'd4);
            end
            if (c >= 13 && !consumed) gaps++;
        end
        check_output("in_ready_dropped", 32'(low_seen), 32'h1);
        check_output("bp_results", 32'(out_seen - base), 32'd10);
        check_output("bp_throughput_gaps", 32'(gaps), 32'd0);

        // Three beats in flight, then a single reset cycle.
        n_acc = 0;
        for (int j = 0; j < 3; j++) begin
            apply_stimulus(1'b1, 16'($urandom), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 1'b1);
            cycle();
            if (accepted) n_acc++;
        end
        check_output("mid_accepted", 32'(n_acc), 32'd3);
        apply_stimulus(1'b0, 16'h0, 4'h0, 3'h0, 1'b1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_reset("mid_reset");
        base = out_seen;
        repeat (10) cycle();
        check_output("ghost_results", 32'(out_seen - base), 32'd0);

        for (int i = 0; i < 300; i++) begin
            apply_stimulus($urandom_range(0, 3) != 0, 16'($urandom), 4'($urandom_range(0, 15)),
                           3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
            cycle();
        end
        apply_stimulus(1'b0, 16'h0, 4'h0, 3'h0, 1'b1);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle();
        check_output("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
